cpu_control: RTL and testbench

Instruction sequencer driving the register-file/ALU memory block of the Mini-CPU. It accepts one 18-bit instruction per valid/ready handshake and decodes it into register-file control fields. It sequences read, execute and write-back phases, holding `we` for the write window the register file needs. It also performs the multi-cycle CLEAR sweep and captures DISPLAY results.

---
 rtl/cpu_control.sv | 188 ++++++++++++++++++
 tb/tb_cpu_control.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control.sv
// Mini-CPU instruction sequencer: accepts 18-bit instructions over valid/ready,
// decodes register-file fields and sequences read/exec/write-back, CLEAR sweep and DISPLAY.
module cpu_control #(
    parameter int unsigned WE_CYCLES   = 2,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  opcode,
    output logic [3:0]  addr1,
    output logic [3:0]  addr2,
    output logic [3:0]  dest,
    output logic        sinalImm,
    output logic [5:0]  Imm,
    output logic        we,
    input  logic [15:0] q1,
    output logic [15:0] disp_data,
    output logic        disp_valid,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_LAST   = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_GAP    = CNT_W'(WE_CYCLES);

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_READ, S_EXEC, S_WRITE, S_CLR, S_SHOW, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             clr_step;

    logic        ready_nxt, busy_nxt, we_nxt, done_nxt, dv_nxt, sign_nxt;
    logic [2:0]  op_nxt;
    logic [3:0]  a1_nxt, a2_nxt, dest_nxt;
    logic [5:0]  imm_nxt;
    logic [15:0] disp_nxt;

    // State register; all outputs are registered from their next-cycle values
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            we          <= 1'b0;
            done        <= 1'b0;
            disp_valid  <= 1'b0;
            disp_data   <= '0;
            opcode      <= '0;
            addr1       <= '0;
            addr2       <= '0;
            dest        <= '0;
            sinalImm    <= 1'b0;
            Imm         <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            instr_ready <= ready_nxt;
            busy        <= busy_nxt;
            we          <= we_nxt;
            done        <= done_nxt;
            disp_valid  <= dv_nxt;
            disp_data   <= disp_nxt;
            opcode      <= op_nxt;
            addr1       <= a1_nxt;
            addr2       <= a2_nxt;
            dest        <= dest_nxt;
            sinalImm    <= sign_nxt;
            Imm         <= imm_nxt;
        end
    end

    // Next state and phase counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_step  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (instr_valid) state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = S_READ;
            S_READ: begin
                if (opcode == OP_DISPLAY) begin
                    state_nxt = S_SHOW;
                end else begin
                    state_nxt = S_EXEC;
                    cnt_nxt   = EXEC_LAST;
                end
            end
            S_EXEC: begin
                if (cnt == '0) begin
                    if (opcode == OP_CLEAR) begin
                        state_nxt = S_CLR;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_WRITE;
                        cnt_nxt   = WE_LAST;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (cnt == '0) state_nxt = S_DONE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            // cnt counts 0..WE_CYCLES: write phases, then a single gap cycle
            S_CLR: begin
                if (cnt == WE_LAST && dest == 4'd15) begin
                    state_nxt = S_DONE;
                end else if (cnt == WE_GAP) begin
                    cnt_nxt  = '0;
                    clr_step = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_SHOW:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output values for the next cycle, including field capture at acceptance
    always_comb begin
        op_nxt   = opcode;
        a1_nxt   = addr1;
        a2_nxt   = addr2;
        dest_nxt = dest;
        sign_nxt = sinalImm;
        imm_nxt  = Imm;
        if (state == S_IDLE && instr_valid) begin
            op_nxt   = instr[17:15];
            a1_nxt   = '0;
            a2_nxt   = '0;
            dest_nxt = '0;
            sign_nxt = 1'b0;
            imm_nxt  = '0;
            case (instr[17:15])
                OP_LOAD: begin
                    dest_nxt = instr[14:11];
                    sign_nxt = instr[6];
                    imm_nxt  = instr[5:0];
                end
                OP_ADD, OP_SUB, OP_MUL: begin
                    dest_nxt = instr[14:11];
                    a1_nxt   = instr[10:7];
                    a2_nxt   = instr[6:3];
                end
                OP_ADDI, OP_SUBI: begin
                    dest_nxt = instr[14:11];
                    a1_nxt   = instr[10:7];
                    sign_nxt = instr[6];
                    imm_nxt  = instr[5:0];
                end
                OP_DISPLAY: a1_nxt = instr[10:7];
                default: ;
            endcase
        end
        if (clr_step) dest_nxt = dest + 4'd1;

        ready_nxt = (state_nxt == S_IDLE);
        busy_nxt  = (state_nxt != S_IDLE);
        done_nxt  = (state_nxt == S_DONE);
        dv_nxt    = (state_nxt == S_SHOW);
        we_nxt    = (state_nxt == S_WRITE) || (state_nxt == S_CLR && cnt_nxt < WE_GAP);
        disp_nxt  = dv_nxt ? q1 : disp_data;
    end

endmodule

// File: tb/tb_cpu_control.sv
// Randomized self-checking bench for cpu_control against a per-cycle schedule model.
module tb_cpu_control;

    localparam int E = 1;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  opcode;
    logic [3:0]  addr1, addr2, dest;
    logic        sinalImm;
    logic [5:0]  Imm;
    logic        we;
    logic [15:0] q1 = '0;
    logic [15:0] disp_data;
    logic        disp_valid, busy, done;

    int errors = 0;
    int checks = 0;

    cpu_control #(.WE_CYCLES(W), .EXEC_CYCLES(E)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .opcode(opcode), .addr1(addr1), .addr2(addr2),
        .dest(dest), .sinalImm(sinalImm), .Imm(Imm), .we(we), .q1(q1),
        .disp_data(disp_data), .disp_valid(disp_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected per-cycle control behaviour of one instruction
    typedef struct packed {
        logic       we;
        logic       busy;
        logic       ready;
        logic       done;
        logic       dv;
        logic       dchk;
        logic [3:0] dest;
    } ent_t;

    ent_t        tl[$];
    logic [2:0]  e_op;
    logic [3:0]  e_dest, e_a1, e_a2;
    logic        e_s;
    logic [5:0]  e_imm;
    logic [15:0] e_disp = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ent_t mk(input logic w, input logic [3:0] d, input logic dchk,
                                input logic dn, input logic dv);
        ent_t e;
        e.we = w; e.busy = 1'b1; e.ready = 1'b0; e.done = dn; e.dv = dv;
        e.dchk = dchk; e.dest = d;
        return e;
    endfunction

    // Field meaning of an instruction word, straight from the opcode table
    task automatic decode_ref(input logic [17:0] w);
        e_op = w[17:15]; e_dest = 0; e_a1 = 0; e_a2 = 0; e_s = 0; e_imm = 0;
        case (w[17:15])
            3'd0: begin e_dest = w[14:11]; e_s = w[6]; e_imm = w[5:0]; end
            3'd1, 3'd3, 3'd5: begin e_dest = w[14:11]; e_a1 = w[10:7]; e_a2 = w[6:3]; end
            3'd2, 3'd4: begin e_dest = w[14:11]; e_a1 = w[10:7]; e_s = w[6]; e_imm = w[5:0]; end
            3'd7: e_a1 = w[10:7];
            default: ;
        endcase
    endtask

    // Phase schedule: decode, read, then exec/write, clear sweep or show, then done
    task automatic build_tl();
        tl.delete();
        tl.push_back(mk(1'b0, e_dest, 1'b1, 1'b0, 1'b0));
        tl.push_back(mk(1'b0, e_dest, 1'b1, 1'b0, 1'b0));
        if (e_op == 3'd7) begin
            tl.push_back(mk(1'b0, e_dest, 1'b1, 1'b0, 1'b1));
        end else begin
            for (int k = 0; k < E; k++) tl.push_back(mk(1'b0, e_dest, 1'b1, 1'b0, 1'b0));
            if (e_op == 3'd6) begin
                for (int r = 0; r < 16; r++) begin
                    for (int k = 0; k < W; k++) tl.push_back(mk(1'b1, 4'(r), 1'b1, 1'b0, 1'b0));
                    if (r < 15) tl.push_back(mk(1'b0, 4'(r), 1'b0, 1'b0, 1'b0));
                end
            end else begin
                for (int k = 0; k < W; k++) tl.push_back(mk(1'b1, e_dest, 1'b1, 1'b0, 1'b0));
            end
        end
        tl.push_back(mk(1'b0, e_dest, (e_op != 3'd6), 1'b1, 1'b0));
    endtask

    // Issue one instruction and follow it cycle by cycle; optionally reset at entry abort_at
    task automatic run_instr(input string tag, input logic [17:0] w, input logic [15:0] qv,
                             input bit noise, input int abort_at);
        logic [4:0]  got_c, exp_c;
        logic [18:0] got_f, exp_f;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept: got %b want 1", tag, instr_ready);
        end
        decode_ref(w);
        build_tl();
        q1 = qv; instr = w; instr_valid = 1'b1;
        step();
        for (int i = 0; i < tl.size(); i++) begin
            instr_valid = noise;
            instr = 18'($urandom);
            got_c = {we, busy, instr_ready, done, disp_valid};
            exp_c = {tl[i].we, tl[i].busy, tl[i].ready, tl[i].done, tl[i].dv};
            checks++;
            if (got_c !== exp_c) begin
                errors++;
                $display("FAIL %s ctl cyc%0d: got we/busy/rdy/done/dv=%b want %b", tag, i + 1, got_c, exp_c);
            end
            got_f = {opcode, addr1, addr2, sinalImm, Imm};
            exp_f = {e_op, e_a1, e_a2, e_s, e_imm};
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL %s fields cyc%0d: got %h want %h", tag, i + 1, got_f, exp_f);
            end
            if (tl[i].dchk) begin
                checks++;
                if (dest !== tl[i].dest) begin
                    errors++;
                    $display("FAIL %s dest cyc%0d: got %0d want %0d", tag, i + 1, dest, tl[i].dest);
                end
            end
            if (tl[i].dv) e_disp = qv;
            checks++;
            if (disp_data !== e_disp) begin
                errors++;
                $display("FAIL %s disp_data cyc%0d: got %h want %h", tag, i + 1, disp_data, e_disp);
            end
            if (i == abort_at) begin
                rst = 1'b1;
                step();
                e_disp = '0;
                got_c = {we, busy, instr_ready, done, disp_valid};
                checks++;
                if (got_c !== 5'b00100 || dest !== 4'd0) begin
                    errors++;
                    $display("FAIL %s after_reset: got ctl=%b dest=%0d want ctl=00100 dest=0", tag, got_c, dest);
                end
                rst = 1'b0; instr_valid = 1'b0;
                step();
                checks++;
                if (done !== 1'b0 || instr_ready !== 1'b1 || we !== 1'b0) begin
                    errors++;
                    $display("FAIL %s post_reset_idle: got done=%b rdy=%b we=%b want 0 1 0", tag, done, instr_ready, we);
                end
                return;
            end
            step();
        end
        instr_valid = 1'b0;
        got_c = {we, busy, instr_ready, done, disp_valid};
        checks++;
        if (got_c !== 5'b00100) begin
            errors++;
            $display("FAIL %s idle_after_done: got we/busy/rdy/done/dv=%b want 00100", tag, got_c);
        end
        checks++;
        if ({opcode, addr1, addr2, sinalImm, Imm} !== {e_op, e_a1, e_a2, e_s, e_imm}) begin
            errors++;
            $display("FAIL %s fields_hold_idle: got %h want %h", tag,
                     {opcode, addr1, addr2, sinalImm, Imm}, {e_op, e_a1, e_a2, e_s, e_imm});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b1; instr = 18'h01805; q1 = 16'hffff;
        step();
        step();
        checks++;
        if ({instr_ready, busy, we, done, disp_valid} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctl: got rdy/busy/we/done/dv=%b want 10000", {instr_ready, busy, we, done, disp_valid});
        end
        checks++;
        if ({opcode, addr1, addr2, dest, sinalImm, Imm, disp_data} !== 39'd0) begin
            errors++;
            $display("FAIL reset_fields: got %h want 0", {opcode, addr1, addr2, dest, sinalImm, Imm, disp_data});
        end
        rst = 1'b0; instr_valid = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_accept: got busy=%b rdy=%b want 0 1", busy, instr_ready);
        end
    endtask

    task automatic test_directed();
        run_instr("load", 18'h01805, 16'h0, 1'b0, -1);
        run_instr("add", {3'b001, 4'd2, 4'd3, 4'd4, 3'd0}, 16'h0, 1'b0, -1);
        run_instr("display", {3'b111, 4'd0, 4'd2, 7'd0}, 16'h0012, 1'b0, -1);
        run_instr("clear", {3'b110, 15'd0}, 16'h0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_clear();
        run_instr("clear_abort", {3'b110, 15'h5a5a}, 16'h0, 1'b0, 2 + E + 7 * (W + 1));
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            logic [2:0] op;
            op = (k % 2 == 0) ? 3'b100 : 3'b101;
            run_instr("b2b", {op, 15'($urandom)}, 16'($urandom), 1'b1, -1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            run_instr("random", 18'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_clear();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
